// File: rtl/mux2_rr_arb.sv
// mux2_rr_arb: two-source round-robin arbiter feeding a registered output slot.
// Source A maps to sel=0 and source B to sel=1, matching the downstream 2:1 mux.
// The slot reloads in the same cycle it drains, so with out_ready held high it
// forwards one word per cycle with one cycle of latency.
// Optional build: define MUX2_RR_ARB_STATS_EN to add saturating grant counters
// cnt_a / cnt_b.
//
// state   | meaning
// S_EMPTY | output slot holds no word (out_valid=0)
// S_FULL  | output slot holds a word waiting for the consumer (out_valid=1)
module mux2_rr_arb #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  input  logic [WIDTH-1:0]     a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [WIDTH-1:0]     b_data,
  output logic                 b_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic                 sel
`ifdef MUX2_RR_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] cnt_a,
  output logic [CNT_WIDTH-1:0] cnt_b
`endif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_q, sel_d;
  logic             prio_q, prio_d;

  logic can_load;
  logic grant_a;
  logic grant_b;
  logic load;

  // Arbitration and readies; prio_q=0 lets A win a tie, prio_q=1 lets B win.
  always_comb begin
    can_load = (state_q == S_EMPTY) | out_ready;
    grant_a  = a_valid & (~b_valid | ~prio_q);
    grant_b  = b_valid & (~a_valid |  prio_q);
    // Readies are held low during reset so no handshake completes that cycle.
    a_ready  = ~rst & can_load & grant_a;
    b_ready  = ~rst & can_load & grant_b;
    load     = a_ready | b_ready;
  end

  // Next-state: slot contents and priority change only when a word is loaded.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    if (load) begin
      data_d = b_ready ? b_data : a_data;
      sel_d  = b_ready;
      // The source not granted now wins the next tie.
      prio_d = ~b_ready;
    end
    case (state_q)
      S_EMPTY: if (load) state_d = S_FULL;
      S_FULL:  if (!load && out_ready) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // State and slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign out_data  = data_q;
  assign sel       = sel_q;

`ifdef MUX2_RR_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_a_q;
  logic [CNT_WIDTH-1:0] cnt_b_q;

  // Grant counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (a_ready && (cnt_a_q != {CNT_WIDTH{1'b1}})) cnt_a_q <= cnt_a_q + 1'b1;
      if (b_ready && (cnt_b_q != {CNT_WIDTH{1'b1}})) cnt_b_q <= cnt_b_q + 1'b1;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_mux2_rr_arb.sv
// Bench for mux2_rr_arb: a table of per-cycle vectors with the expected readies
// and slot contents, plus a scoreboard that records every accepted input word
// and checks it against each output handshake in order.
module tb_mux2_rr_arb;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 2;

  logic             clk;
  logic             rst;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             sel;
`ifdef MUX2_RR_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_a;
  logic [CNT_WIDTH-1:0] cnt_b;
`endif

  mux2_rr_arb #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel)
`ifdef MUX2_RR_ARB_STATS_EN
    ,
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             av;
    logic [WIDTH-1:0] ad;
    logic             bv;
    logic [WIDTH-1:0] bd;
    logic             ordy;
    logic             ear;
    logic             ebr;
    logic             eov;
    logic [WIDTH-1:0] eod;
    logic             esel;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic void add(input logic r, input logic av, input logic [7:0] ad,
                              input logic bv, input logic [7:0] bd, input logic ordy,
                              input logic ear, input logic ebr, input logic eov,
                              input logic [7:0] eod, input logic esel);
    vec_t v;
    v.rst = r; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
    v.ear = ear; v.ebr = ebr; v.eov = eov; v.eod = eod; v.esel = esel;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] exp_w;

    //    rst av ad     bv bd     ordy  ar br ov od     sel
    // reset held with both sources requesting
    add(1, 1, 8'hAA, 1, 8'hBB, 1,   0, 0, 0, 8'h00, 0);
    add(1, 1, 8'hAA, 1, 8'hBB, 1,   0, 0, 0, 8'h00, 0);
    add(1, 1, 8'hAA, 1, 8'hBB, 1,   0, 0, 0, 8'h00, 0);
    // alternation under continuous ties
    add(0, 1, 8'h11, 1, 8'h33, 1,   1, 0, 0, 8'h00, 0);
    add(0, 1, 8'h22, 1, 8'h33, 1,   0, 1, 1, 8'h11, 0);
    add(0, 1, 8'h22, 1, 8'h44, 1,   1, 0, 1, 8'h33, 1);
    add(0, 0, 8'h00, 1, 8'h44, 1,   0, 1, 1, 8'h22, 0);
    // load 0x5A, then stall four cycles with B waiting
    add(0, 1, 8'h5A, 0, 8'h00, 1,   1, 0, 1, 8'h44, 1);
    add(0, 0, 8'h00, 1, 8'hC3, 0,   0, 0, 1, 8'h5A, 0);
    add(0, 0, 8'h00, 1, 8'hC3, 0,   0, 0, 1, 8'h5A, 0);
    add(0, 0, 8'h00, 1, 8'hC3, 0,   0, 0, 1, 8'h5A, 0);
    add(0, 0, 8'h00, 1, 8'hC3, 0,   0, 0, 1, 8'h5A, 0);
    add(0, 0, 8'h00, 1, 8'hC3, 1,   0, 1, 1, 8'h5A, 0);
    // drain without load: data/sel hold after out_valid drops
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 1, 8'hC3, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 8'hC3, 1);
    // lone B for three words, then A wins the first tie
    add(0, 0, 8'h00, 1, 8'hB1, 1,   0, 1, 0, 8'hC3, 1);
    add(0, 0, 8'h00, 1, 8'hB2, 1,   0, 1, 1, 8'hB1, 1);
    add(0, 0, 8'h00, 1, 8'hB3, 1,   0, 1, 1, 8'hB2, 1);
    add(0, 1, 8'hA1, 1, 8'hB4, 1,   1, 0, 1, 8'hB3, 1);
    add(0, 0, 8'h00, 1, 8'hB4, 1,   0, 1, 1, 8'hA1, 0);
    // reset while 0x77 sits in the slot
    add(0, 1, 8'h77, 0, 8'h00, 1,   1, 0, 1, 8'hB4, 1);
    add(1, 1, 8'h88, 1, 8'h99, 1,   0, 0, 1, 8'h77, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 8'h00, 0);
    // priority back to A after reset; stall and drain of a single word
    add(0, 1, 8'hAA, 1, 8'hBB, 1,   1, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0,   0, 0, 1, 8'hAA, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 1, 8'hAA, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 8'hAA, 0);
    // empty slot loads even while the consumer is not ready
    add(0, 0, 8'h00, 1, 8'hCC, 0,   0, 1, 0, 8'hAA, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 1, 8'hCC, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 8'hCC, 1);

    rst = 1'b1; a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; a_valid = vecs[i].av; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_data = vecs[i].bd; out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d a_ready", i),   32'(a_ready),   32'(vecs[i].ear));
      chk($sformatf("v%0d b_ready", i),   32'(b_ready),   32'(vecs[i].ebr));
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
      chk($sformatf("v%0d out_data", i),  32'(out_data),  32'(vecs[i].eod));
      chk($sformatf("v%0d sel", i),       32'(sel),       32'(vecs[i].esel));
      if (vecs[i].rst) begin
        sb.delete();
      end else begin
        if (out_valid && vecs[i].ordy) begin
          if (sb.size() == 0) begin
            chk($sformatf("v%0d unexpected output word", i), 32'({sel, out_data}), 32'h1FF);
          end else begin
            exp_w = sb.pop_front();
            chk($sformatf("v%0d scoreboard word", i), 32'({sel, out_data}), 32'(exp_w));
          end
        end
        if (vecs[i].av && vecs[i].ear) sb.push_back({1'b0, vecs[i].ad});
        if (vecs[i].bv && vecs[i].ebr) sb.push_back({1'b1, vecs[i].bd});
      end
      @(posedge clk); #1;
    end
    chk("scoreboard empty at end", 32'(sb.size()), 32'd0);

`ifdef MUX2_RR_ARB_STATS_EN
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("cnt_a after reset", 32'(cnt_a), 32'd0);
    chk("cnt_b after reset", 32'(cnt_b), 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      a_valid = 1'b1; a_data = 8'(k + 1);
      @(negedge clk);
      chk($sformatf("stats a_ready %0d", k), 32'(a_ready), 32'd1);
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    @(negedge clk);
    chk("cnt_a saturated", 32'(cnt_a), 32'd3);
    chk("cnt_b idle", 32'(cnt_b), 32'd0);
    @(posedge clk); #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
